// File: rtl/cpu_mul_pipeline.sv
// cpu_mul_pipeline: STAGES-deep multiply pipeline with writeback backpressure, flush and hazard query.
// Define CPU_MUL_HIGH_EN to enable upper-half product selection via in_high.
module cpu_mul_pipeline #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5,
  parameter int RID_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic               in_high,
  input  logic [RID_W-1:0]   in_rd,
  input  logic               flush,
  output logic               wb_valid,
  output logic [RID_W-1:0]   wb_rd,
  output logic [WIDTH-1:0]   wb_data,
  input  logic               wb_ready,
  input  logic [RID_W-1:0]   chk_rd,
  output logic               chk_hit,
  output logic [STAGES-1:0]  busy
);
  logic [STAGES-1:0] s_valid;
  logic [RID_W-1:0]  s_rd  [STAGES];
  logic [WIDTH-1:0]  s_res [STAGES];
  logic [WIDTH-1:0]  result;
  logic              advance;
`ifdef CPU_MUL_HIGH_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  assign ext_a  = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
  assign ext_b  = in_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};
  assign prod   = ext_a * ext_b;
  assign result = in_high ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
`else
  // The low half of the product is the same for signed and unsigned operands.
  logic unused_ops;
  assign result     = in_a * in_b;
  assign unused_ops = ^{in_signed, in_high};
`endif
  assign advance  = !s_valid[STAGES-1] || wb_ready;
  assign in_ready = advance;
  assign wb_valid = s_valid[STAGES-1];
  assign wb_rd    = s_rd[STAGES-1];
  assign wb_data  = s_res[STAGES-1];
  assign busy     = s_valid;
  always_ff @(posedge clock) begin
    if (reset) begin
      s_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        s_rd[i]  <= '0;
        s_res[i] <= '0;
      end
    end else if (flush) begin
      s_valid <= '0;
    end else if (advance) begin
      s_valid[0] <= in_valid;
      s_rd[0]    <= in_rd;
      s_res[0]   <= result;
      for (int i = 1; i < STAGES; i++) begin
        s_valid[i] <= s_valid[i-1];
        s_rd[i]    <= s_rd[i-1];
        s_res[i]   <= s_res[i-1];
      end
    end
  end
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < STAGES; i++) chk_hit = chk_hit | (s_valid[i] && s_rd[i] == chk_rd);
  end
endmodule

// File: doc/cpu_mul_pipeline.md
CPU_MUL_PIPELINE -- requirements
Module: cpu_mul_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width.
REQ-002 SHALL have parameter STAGES, default 5, pipeline depth (legal range 1..8).
REQ-003 SHALL have parameter RID_W, default 4, destination register id width.
REQ-004 SHALL have port clock  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  operation offered.
REQ-007 SHALL have port in_ready  out  1  operation accepted when in_valid&&in_ready.
REQ-008 SHALL have port in_a, in_b  in  WIDTH each  operands.
REQ-009 SHALL have port in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port in_high  in  1  upper-half result select (see Configuration).
REQ-011 SHALL have port in_rd  in  RID_W  destination register id.
REQ-012 SHALL have port flush  in  1  kill all in-flight operations.
REQ-013 SHALL have port wb_valid, wb_rd, wb_data  out  1/RID_W/WIDTH  writeback.
REQ-014 SHALL have port wb_ready  in  1  writeback consumer accepts.
REQ-015 SHALL have port chk_rd  in  RID_W  hazard query id.
REQ-016 SHALL have port chk_hit  out  1  a valid stage targets chk_rd.
REQ-017 SHALL have port busy  out  STAGES  per-stage valid bits, bit 0 = youngest.

Function
REQ-018 SHALL hold STAGES registers s[0..STAGES-1], each {valid, rd, result}; wb_* SHALL be driven directly from s[STAGES-1].
REQ-019 SHALL compute advance = !s[STAGES-1].valid || wb_ready; in_ready SHALL equal advance (combinational, no dependency on in_valid).
REQ-020 On advance, s[0] SHALL load {in_valid, in_rd, result} and s[i] SHALL load s[i-1]; otherwise all stages SHALL hold (no bubble compaction).
REQ-021 SHALL form the full 2*WIDTH product, signed or unsigned per in_signed; result SHALL be bits [WIDTH-1:0] unless Configuration selects upper half.
REQ-022 Latency SHALL be exactly STAGES cycles from accept cycle to wb_valid cycle with no stall; throughput one per cycle.
REQ-023 A writeback completes in a cycle with wb_valid&&wb_ready; wb_* SHALL stay stable while wb_valid&&!wb_ready.
REQ-024 flush SHALL clear every stage valid at the next edge, taking priority over advance; an op offered in the flush cycle SHALL be discarded though in_ready may read 1.
REQ-025 chk_hit SHALL be combinational: OR over stages of (s[i].valid && s[i].rd==chk_rd), including s[STAGES-1].
REQ-026 rd value 0 SHALL receive no special treatment.

Reset
REQ-027 reset SHALL clear all s[i] fields to 0 at the next edge: wb_valid=0, wb_rd=0, wb_data=0, busy=0, chk_hit=0; in_ready=1 after reset.
REQ-028 reset SHALL take priority over flush and accept; ops in flight when reset asserts SHALL never reach wb.

Configuration
REQ-029 Macro CPU_MUL_HIGH_EN: when defined, in_high=1 SHALL select product bits [2*WIDTH-1:WIDTH]; when undefined, in_high SHALL be ignored and only the low half SHALL be produced (upper-half logic absent).

Verification
REQ-030 STAGES=5, wb_ready=1: accept a=7,b=6,rd=3 at cycle 0 -> wb_valid=1, wb_rd=3, wb_data=42 at cycle 5 only.
REQ-031 Signed: a=0xFFFFFFFD (-3), b=5, in_signed=1 -> wb_data=0xFFFFFFF1; with CPU_MUL_HIGH_EN, in_high=1 -> 0xFFFFFFFF; unsigned same operands, in_high=1 -> 0x00000004.
REQ-032 Back-to-back 8 ops, wb_ready=0 for 3 cycles when first reaches wb -> in_ready=0 those cycles, wb_data held, all 8 results emitted in order, none lost or duplicated.
REQ-033 Ops rd=2, rd=9 in flight; chk_rd=9 -> chk_hit=1 until rd=9 writeback completes; chk_rd=4 -> chk_hit=0.
REQ-034 Three ops in flight, flush pulsed with in_valid=1 -> next cycle busy=0, no wb_valid ever for those four ops; reset mid-stream -> same, wb_data=0.
